// File: rtl/hwag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hwag_pkg
// Purpose  : Shared constants, types and helpers for the HWAG register bank.
//            BYTE_W   - byte lane width
//            DEF_*    - default bank geometry
//            bus_rsp_t- registered bus response {ack, err}
//            lanes()  - number of byte lanes in a data word
// Revision : 1.0 - initial release
// ============================================================================
package hwag_pkg;

    localparam int BYTE_W     = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_NREG   = 64;

    typedef struct packed {
        logic ack;
        logic err;
    } bus_rsp_t;

    function automatic int lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwag_reg_cell.sv
`default_nettype none
// ============================================================================
// Module   : hwag_reg_cell
// Purpose  : One host/hardware register with byte-lane write merge.
//            The hardware update port always wins over a bus write in the
//            same cycle; a read-only cell ignores bus writes entirely.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_bus_wr        - decoded, otherwise-legal bus write to this cell
//            i_bus_be        - byte enables for the bus write
//            i_bus_wdata     - bus write data
//            i_hw_we         - hardware full-width update enable
//            i_hw_wdata      - hardware update data
//            o_q             - current register contents
//            o_wr_err        - bus write to this cell rejected (RO/collision)
//            o_wr_ok         - bus write lands with at least one lane enabled
// Revision : 1.0 - initial release
// ============================================================================
module hwag_reg_cell
    import hwag_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter bit RO     = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_bus_wr,
    input  logic [lanes(DATA_W)-1:0]    i_bus_be,
    input  logic [DATA_W-1:0]           i_bus_wdata,
    input  logic                        i_hw_we,
    input  logic [DATA_W-1:0]           i_hw_wdata,
    output logic [DATA_W-1:0]           o_q,
    output logic                        o_wr_err,
    output logic                        o_wr_ok
);

    localparam int c_LANES = lanes(DATA_W);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_merged;
    logic              w_bus_land;

    generate
        for (genvar k = 0; k < c_LANES; k++) begin : g_lane
            assign w_merged[k*BYTE_W +: BYTE_W] = i_bus_be[k] ? i_bus_wdata[k*BYTE_W +: BYTE_W]
                                                              : r_q[k*BYTE_W +: BYTE_W];
        end
    endgenerate

    // A bus write only lands when the cell is writable and hardware is not
    // updating it in the same cycle.
    assign w_bus_land = i_bus_wr && !RO && !i_hw_we;
    assign o_wr_err   = i_bus_wr && (RO || i_hw_we);
    assign o_wr_ok    = w_bus_land && (|i_bus_be);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_hw_we) begin
            r_q <= i_hw_wdata;
        end else if (w_bus_land) begin
            r_q <= w_merged;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/hwag_regbank.sv
`default_nettype none
// ============================================================================
// Module   : hwag_regbank
// Purpose  : Parametrised host-visible register bank for the HWAG core.
//            Single-cycle request, registered ack/err one cycle later,
//            byte enables, read-only mask, hardware update port with
//            priority, per-register write strobes.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            bus_we/bus_re         - host write/read request
//            bus_addr              - word address
//            bus_wdata/bus_be      - write data and byte enables
//            bus_rdata             - read data, held until next read ack
//            bus_ack/bus_err       - one-cycle completion pulse and error flag
//            hw_we/hw_wdata        - hardware update enables and flat data
//            regs_out              - flat register contents
//            wr_strobe             - pulse per successful bus write
// Revision : 1.0 - initial release
// ============================================================================
module hwag_regbank
    import hwag_pkg::*;
#(
    parameter int              DATA_W  = DEF_DATA_W,
    parameter int              ADDR_W  = DEF_ADDR_W,
    parameter int              NREG    = DEF_NREG,
    parameter logic [NREG-1:0] RO_MASK = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_we,
    input  logic                     bus_re,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_wdata,
    input  logic [lanes(DATA_W)-1:0] bus_be,
    output logic [DATA_W-1:0]        bus_rdata,
    output logic                     bus_ack,
    output logic                     bus_err,
    input  logic [NREG-1:0]          hw_we,
    input  logic [NREG*DATA_W-1:0]   hw_wdata,
    output logic [NREG*DATA_W-1:0]   regs_out,
    output logic [NREG-1:0]          wr_strobe
);

    localparam logic [ADDR_W:0] c_NREG = (ADDR_W+1)'(NREG);

    logic [DATA_W-1:0] w_q [NREG];
    logic [NREG-1:0]   w_cell_err;
    logic [NREG-1:0]   w_cell_ok;
    logic              w_req;
    logic              w_both;
    logic              w_mapped;
    logic              w_wr_valid;
    logic              w_err;
    logic [DATA_W-1:0] w_rd_word;
    bus_rsp_t          w_rsp;

    bus_rsp_t          r_rsp;
    logic [DATA_W-1:0] r_rdata;
    logic [NREG-1:0]   r_strobe;

    assign w_req      = bus_we || bus_re;
    assign w_both     = bus_we && bus_re;
    assign w_mapped   = ({1'b0, bus_addr} < c_NREG);
    assign w_wr_valid = bus_we && !bus_re && w_mapped;

    generate
        for (genvar i = 0; i < NREG; i++) begin : g_reg
            hwag_reg_cell #(
                .DATA_W (DATA_W),
                .RO     (RO_MASK[i])
            ) u_cell (
                .clk         (clk),
                .rst         (rst),
                .i_bus_wr    (w_wr_valid && (bus_addr == ADDR_W'(i))),
                .i_bus_be    (bus_be),
                .i_bus_wdata (bus_wdata),
                .i_hw_we     (hw_we[i]),
                .i_hw_wdata  (hw_wdata[i*DATA_W +: DATA_W]),
                .o_q         (w_q[i]),
                .o_wr_err    (w_cell_err[i]),
                .o_wr_ok     (w_cell_ok[i])
            );
            assign regs_out[i*DATA_W +: DATA_W] = w_q[i];
        end
    endgenerate

    // Read mux over current register contents; unmapped addresses match no
    // entry and therefore return zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bus_addr == ADDR_W'(i)) begin
                w_rd_word = w_q[i];
            end
        end
    end

    assign w_err   = w_both || !w_mapped || (|w_cell_err);
    assign w_rsp   = '{ack: w_req, err: w_req && w_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp    <= '0;
            r_rdata  <= '0;
            r_strobe <= '0;
        end else begin
            r_rsp    <= w_rsp;
            r_strobe <= w_cell_ok;
            if (bus_re && !bus_we) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // A response already registered when reset rises is swallowed so the
    // host never sees an ack for a request that reset cancelled.
    assign bus_ack   = r_rsp.ack && !rst;
    assign bus_err   = r_rsp.err && !rst;
    assign wr_strobe = r_strobe & {NREG{!rst}};
    assign bus_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hwag_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hwag_regbank
// Purpose  : Directed self-checking bench for hwag_regbank (16-bit, 64 regs,
//            reg 3 read-only).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hwag_regbank;

    logic          clk = 1'b0;
    logic          rst;
    logic          bus_we;
    logic          bus_re;
    logic [7:0]    bus_addr;
    logic [15:0]   bus_wdata;
    logic [1:0]    bus_be;
    logic [15:0]   bus_rdata;
    logic          bus_ack;
    logic          bus_err;
    logic [63:0]   hw_we;
    logic [1023:0] hw_wdata;
    logic [1023:0] regs_out;
    logic [63:0]   wr_strobe;

    int total = 0;
    int bad   = 0;

    hwag_regbank #(
        .DATA_W  (16),
        .ADDR_W  (8),
        .NREG    (64),
        .RO_MASK (64'h8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .hw_we     (hw_we),
        .hw_wdata  (hw_wdata),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] reg_of(input int i);
        return regs_out[i*16 +: 16];
    endfunction

    // Present one request for one cycle, then land on the following negedge
    // where the response for that request is visible.
    task automatic step(input logic we, input logic re, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be);
        bus_we    = we;
        bus_re    = re;
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_be    = be;
        @(posedge clk);
        #1;
        bus_we = 1'b0;
        bus_re = 1'b0;
        bus_be = 2'b00;
        hw_we  = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0;
        bus_wdata = '0; bus_be = '0; hw_we = '0; hw_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ack", 64'(bus_ack), 64'd0);
        chk("rst_strobe", wr_strobe, 64'd0);
        chk("rst_regs_zero", 64'(regs_out == '0), 64'd1);

        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, 8'(i), 16'h0, 2'b00);
            chk($sformatf("rd%0d_ack", i), 64'(bus_ack), 64'd1);
            chk($sformatf("rd%0d_err", i), 64'(bus_err), 64'd0);
            chk($sformatf("rd%0d_data", i), 64'(bus_rdata), 64'd0);
        end

        step(1'b0, 1'b1, 8'd64, 16'h0, 2'b00);
        chk("rd64_ack", 64'(bus_ack), 64'd1);
        chk("rd64_err", 64'(bus_err), 64'd1);
        chk("rd64_data", 64'(bus_rdata), 64'd0);

        // Full write then read back
        step(1'b1, 1'b0, 8'd5, 16'hA55A, 2'b11);
        chk("wr5_ack", 64'(bus_ack), 64'd1);
        chk("wr5_err", 64'(bus_err), 64'd0);
        chk("wr5_strobe", wr_strobe, 64'h20);
        chk("wr5_reg", 64'(reg_of(5)), 64'hA55A);
        step(1'b0, 1'b1, 8'd5, 16'h0, 2'b00);
        chk("rd5_ack", 64'(bus_ack), 64'd1);
        chk("rd5_err", 64'(bus_err), 64'd0);
        chk("rd5_data", 64'(bus_rdata), 64'hA55A);
        chk("rd5_strobe", wr_strobe, 64'd0);

        // Byte-lane merge, then empty byte enable
        step(1'b1, 1'b0, 8'd5, 16'h1234, 2'b01);
        chk("be01_strobe", wr_strobe, 64'h20);
        chk("be01_reg", 64'(reg_of(5)), 64'hA534);
        step(1'b1, 1'b0, 8'd5, 16'hFFFF, 2'b00);
        chk("be00_ack", 64'(bus_ack), 64'd1);
        chk("be00_err", 64'(bus_err), 64'd0);
        chk("be00_strobe", wr_strobe, 64'd0);
        chk("be00_reg", 64'(reg_of(5)), 64'hA534);
        step(1'b1, 1'b0, 8'd5, 16'h7700, 2'b10);
        chk("be10_reg", 64'(reg_of(5)), 64'h7734);

        // Read-only register: bus rejected, hardware accepted
        step(1'b1, 1'b0, 8'd3, 16'hFFFF, 2'b11);
        chk("ro3_ack", 64'(bus_ack), 64'd1);
        chk("ro3_err", 64'(bus_err), 64'd1);
        chk("ro3_strobe", wr_strobe, 64'd0);
        chk("ro3_reg", 64'(reg_of(3)), 64'h0);
        hw_we[3] = 1'b1;
        hw_wdata[3*16 +: 16] = 16'h00C3;
        step(1'b0, 1'b0, 8'd0, 16'h0, 2'b00);
        chk("hw3_reg", 64'(reg_of(3)), 64'h00C3);
        chk("hw3_ack", 64'(bus_ack), 64'd0);

        // Bus/hardware collision on reg 7
        hw_we[7] = 1'b1;
        hw_wdata[7*16 +: 16] = 16'h2222;
        step(1'b1, 1'b0, 8'd7, 16'h1111, 2'b11);
        chk("col7_reg", 64'(reg_of(7)), 64'h2222);
        chk("col7_ack", 64'(bus_ack), 64'd1);
        chk("col7_err", 64'(bus_err), 64'd1);
        chk("col7_strobe", wr_strobe, 64'd0);

        // Read returns value before a same-cycle hardware update
        hw_we[5] = 1'b1;
        hw_wdata[5*16 +: 16] = 16'hBEEF;
        step(1'b0, 1'b1, 8'd5, 16'h0, 2'b00);
        chk("rdhw5_data", 64'(bus_rdata), 64'h7734);
        chk("rdhw5_reg", 64'(reg_of(5)), 64'hBEEF);

        // Unmapped write
        step(1'b1, 1'b0, 8'd200, 16'hFFFF, 2'b11);
        chk("wr200_err", 64'(bus_err), 64'd1);
        chk("wr200_strobe", wr_strobe, 64'd0);
        chk("wr200_rdata_hold", 64'(bus_rdata), 64'h7734);

        // Back-to-back: write, read, we&re, reset
        step(1'b1, 1'b0, 8'd9, 16'h5A5A, 2'b11);
        chk("b2b_wr_ack", 64'(bus_ack), 64'd1);
        chk("b2b_wr_err", 64'(bus_err), 64'd0);
        chk("b2b_wr_strobe", wr_strobe, 64'h200);
        step(1'b0, 1'b1, 8'd9, 16'h0, 2'b00);
        chk("b2b_rd_ack", 64'(bus_ack), 64'd1);
        chk("b2b_rd_data", 64'(bus_rdata), 64'h5A5A);
        bus_we = 1'b1; bus_re = 1'b1; bus_addr = 8'd9; bus_wdata = 16'hFFFF; bus_be = 2'b11;
        @(posedge clk);
        #1;
        bus_we = 1'b0; bus_re = 1'b0; bus_be = 2'b00;
        rst = 1'b1;
        #1;
        chk("b2b_n3_ack", 64'(bus_ack), 64'd0);
        chk("b2b_n3_err", 64'(bus_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("b2b_n4_ack", 64'(bus_ack), 64'd0);
        chk("b2b_n4_err", 64'(bus_err), 64'd0);
        chk("b2b_n4_rdata", 64'(bus_rdata), 64'd0);
        chk("b2b_n4_strobe", wr_strobe, 64'd0);
        chk("b2b_n4_regs_zero", 64'(regs_out == '0), 64'd1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
